// File: rtl/fire_pkg.sv
// ============================================================================
// Module      : fire_pkg
// Description : Shared Fire-code datapath constants and the burst LFSR step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fire_pkg;

  localparam int N = 64;
  localparam int K = 40;
  localparam int B = 8;

  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  // Galois right-shift step: feedback taps are applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/burst_lfsr.sv
// ============================================================================
// Module      : burst_lfsr
// Description : 16-bit Galois LFSR with step enable and a seed load that
//               replaces an all-zero seed with 0x0001 to avoid lock-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_lfsr
  import fire_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_step,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // A load takes priority over a step in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LFSR_RESET;
    end else if (i_load) begin
      r_state <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/burst_channel.sv
// ============================================================================
// Module      : burst_channel
// Description : Burst-error channel model; XORs an LFSR-driven cyclic burst
//               into accepted codewords. Optional statistics counters are
//               built when BURST_CHANNEL_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_channel
  import fire_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  cw_in,
  input  logic          cw_valid,
  output logic          cw_ready,
  output logic [N-1:0]  out_data,
  output logic [N-1:0]  err_mask,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic [3:0]    burst_len,
  input  logic [7:0]    inj_period,
  input  logic [15:0]   seed,
  input  logic          seed_load,
  output logic [31:0]   frame_count,
  output logic [31:0]   burst_count
);

  localparam int         c_pos_w     = $clog2(N);
  localparam logic [3:0] c_burst_max = 4'(B);

  logic               r_out_valid;
  logic [N-1:0]       r_out_data;
  logic [N-1:0]       r_err_mask;
  logic [7:0]         r_phase;

  logic [15:0]        w_lfsr;
  logic               w_accept;
  logic               w_inject;
  logic [3:0]         w_len;
  logic [7:0]         w_period_m1;
  logic [c_pos_w-1:0] w_pos;
  logic [B-1:0]       w_burst_bits;
  logic [N-1:0]       w_mask;

  assign cw_ready = !r_out_valid || out_ready;
  assign w_accept = cw_valid && cw_ready;

  burst_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_step  (w_accept),
    .i_load  (seed_load),
    .i_seed  (seed),
    .o_state (w_lfsr)
  );

  assign w_len       = (burst_len > c_burst_max) ? c_burst_max : burst_len;
  assign w_period_m1 = inj_period - 8'd1;
  // ">=" rather than "==" so a shortened period still fires on the next accept.
  assign w_inject    = (inj_period != 8'd0) && (r_phase >= w_period_m1);
  assign w_pos       = w_lfsr[c_pos_w-1:0];

  // Burst pattern in burst-relative order: ends forced high, interior from the LFSR.
  always_comb begin
    w_burst_bits = '0;
    for (int i = 0; i < B; i++) begin
      if (4'(i) < w_len) begin
        w_burst_bits[i] = (i == 0) || (4'(i) == (w_len - 4'd1)) || w_lfsr[6+i];
      end
    end
  end

  // Rotate the pattern onto the codeword; the position arithmetic wraps mod N.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < B; i++) begin
      if (w_inject && w_burst_bits[i]) begin
        w_mask[w_pos + c_pos_w'(i)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 8'd0;
    end else if (w_accept) begin
      if ((inj_period == 8'd0) || w_inject) begin
        r_phase <= 8'd0;
      end else begin
        r_phase <= r_phase + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err_mask  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= cw_in ^ w_mask;
      r_err_mask  <= w_mask;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_mask  = r_err_mask;

`ifdef BURST_CHANNEL_STATS_EN
  logic [31:0] r_frame_count;
  logic [31:0] r_burst_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= 32'd0;
      r_burst_count <= 32'd0;
    end else if (w_accept) begin
      r_frame_count <= r_frame_count + 32'd1;
      if (|w_mask) begin
        r_burst_count <= r_burst_count + 32'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign burst_count = r_burst_count;
`else
  assign frame_count = 32'd0;
  assign burst_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_burst_channel.sv
// ============================================================================
// Module      : tb_burst_channel
// Description : Scoreboard bench for burst_channel with a reference model of
//               the LFSR, injection schedule and cyclic burst mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_burst_channel;

  logic        clk;
  logic        rst;
  logic [63:0] cw_in;
  logic        cw_valid;
  logic        cw_ready;
  logic [63:0] out_data;
  logic [63:0] err_mask;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  burst_len;
  logic [7:0]  inj_period;
  logic [15:0] seed;
  logic        seed_load;
  logic [31:0] frame_count;
  logic [31:0] burst_count;

  burst_channel dut (
    .clk         (clk),
    .rst         (rst),
    .cw_in       (cw_in),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .out_data    (out_data),
    .err_mask    (err_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .burst_len   (burst_len),
    .inj_period  (inj_period),
    .seed        (seed),
    .seed_load   (seed_load),
    .frame_count (frame_count),
    .burst_count (burst_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;

  logic [15:0] m_s;
  int          m_phase;
  logic [31:0] m_frames;
  logic [31:0] m_bursts;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] model_mask(input logic [15:0] s, input int len);
    logic [63:0] m;
    int l;
    int p;
    m = '0;
    l = (len > 8) ? 8 : len;
    p = int'(s) % 64;
    for (int i = 0; i < l; i++) begin
      if (i == 0 || i == l - 1 || s[6+i]) m[(p + i) % 64] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic check_stats();
`ifdef BURST_CHANNEL_STATS_EN
    chk("frame_count", 64'(frame_count), 64'(m_frames));
    chk("burst_count", 64'(burst_count), 64'(m_bursts));
`else
    chk("frame_count_off", 64'(frame_count), 64'd0);
    chk("burst_count_off", 64'(burst_count), 64'd0);
`endif
  endtask

  // Called at posedge+1; drives one cycle and returns at posedge+1 of the next.
  task automatic step(input logic v, input logic [63:0] d, input logic rdy,
                      input int len, input int per, input logic sl, input logic [15:0] sd);
    logic        acc;
    logic        inj;
    logic [63:0] m;
    exp_t        e;
    e.data = '0;
    e.mask = '0;
    m = '0;
    cw_valid   = v;
    cw_in      = d;
    out_ready  = rdy;
    burst_len  = 4'(len);
    inj_period = 8'(per);
    seed_load  = sl;
    seed       = sd;
    acc = v && ((q.size() == 0) || rdy);
    #1;
    chk("cw_ready", 64'(cw_ready), 64'((q.size() == 0) || rdy));
    if (acc) begin
      if (per == 0) begin
        inj = 1'b0;
        m_phase = 0;
      end else if (m_phase >= per - 1) begin
        inj = 1'b1;
        m_phase = 0;
      end else begin
        inj = 1'b0;
        m_phase++;
      end
      m = inj ? model_mask(m_s, len) : 64'd0;
      e.data = d ^ m;
      e.mask = m;
    end
    if (sl) m_s = (sd == 16'd0) ? 16'd1 : sd;
    else if (acc) m_s = model_step(m_s);
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    if (acc) begin
      q.push_back(e);
      m_frames++;
      if (m != 64'd0) m_bursts++;
    end
    check_stats();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cw_valid  = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_s      = 16'hACE1;
    m_phase  = 0;
    m_frames = 32'd0;
    m_bursts = 32'd0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_err_mask", err_mask, 64'd0);
    chk("rst_cw_ready", 64'(cw_ready), 64'd1);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_burst_count", 64'(burst_count), 64'd0);
  endtask

  // Monitor: compares the head of the scoreboard whenever the DUT presents a word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            chk("out_data", out_data, q[0].data);
            chk("err_mask", err_mask, q[0].mask);
            if (out_ready) void'(q.pop_front());
          end
        end else begin
          chk("missing_out_valid", 64'(q.size()), 64'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cw_in = '0; cw_valid = 1'b0; out_ready = 1'b1;
    burst_len = '0; inj_period = '0; seed = '0; seed_load = 1'b0;
    m_s = 16'hACE1; m_phase = 0; m_frames = '0; m_bursts = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single-bit error at P=33 from the reset seed.
    step(1'b1, 64'd0, 1'b1, 1, 1, 1'b0, 16'd0);
    chk("first_mask", err_mask, 64'h0000_0002_0000_0000);
    chk("first_data", out_data, 64'h0000_0002_0000_0000);

    // L=0 passes data through.
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1, 1'b0, 16'd0);
    chk("l0_data", out_data, 64'h0123_4567_89AB_CDEF);

    // Wrapping burst from seed 0x003E.
    step(1'b0, 64'd0, 1'b1, 4, 1, 1'b1, 16'h003E);
    step(1'b1, 64'd0, 1'b1, 4, 1, 1'b0, 16'd0);
    chk("wrap_mask", err_mask, 64'h4000_0000_0000_0002);

    // Stall for 10 cycles, then release.
    step(1'b1, 64'hDEAD_BEEF_0000_1111, 1'b0, 5, 1, 1'b0, 16'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0, 5, 1, 1'b0, 16'd0);
    step(1'b1, 64'h1234_0000_0000_4321, 1'b1, 3, 1, 1'b0, 16'd0);
    step(1'b0, 64'd0, 1'b1, 3, 1, 1'b0, 16'd0);

    // Period 3, L=2: frames 3 and 6 only.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, {$urandom, $urandom}, 1'b1, 2, 3, 1'b0, 16'd0);
`ifdef BURST_CHANNEL_STATS_EN
    chk("period3_frames", 64'(frame_count), 64'd6);
    chk("period3_bursts", 64'(burst_count), 64'd2);
`endif

    // Zero seed coincident with accept; next frame uses S=1, a single bit at P=1.
    step(1'b1, 64'hFFFF_0000_FFFF_0000, 1'b1, 1, 1, 1'b1, 16'h0000);
    step(1'b1, 64'd0, 1'b1, 1, 1, 1'b0, 16'd0);
    chk("seed0_mask", err_mask, 64'h0000_0000_0000_0002);

    // Reset during a stall discards the pending word.
    step(1'b1, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 8, 1, 1'b0, 16'd0);
    step(1'b0, 64'd0, 1'b0, 8, 1, 1'b0, 16'd0);
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
             $urandom_range(0, 15) == 0,
             ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 0, 0, 1'b0, 16'd0);
    chk("drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
